fb_scanout: RTL
===============

Name: fb_scanout

Overview:
- Downstream consumer of the sprite/graphics drawing engine's 64x64 12-bit frame buffer (FB single-port SRAM).
- On a frame_go pulse (wired to the engine's done), takes ownership of the FB port and reads all pixels in raster order.
- Streams pixels with coordinates and frame/line markers on a valid/ready interface to the display/encoder stage.
- A 2-entry skid buffer absorbs the 1-cycle SRAM read latency under backpressure.

Parameters:
- PIX_W, 12, pixel word width (FB data width).
- XW, 6, log2 of frame width (64 columns).
- YW, 6, log2 of frame height (64 rows); FB address width = XW+YW = 12.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- frame_go  in  1  start pulse; sampled only in IDLE.
- busy  out  1  high from the cycle after frame_go is accepted until frame_done.
- own_bus  out  1  top-level FB mux select; 1 = this block drives FB_CEN/FB_WEN/FB_A.
- FB_CEN  out  1  FB chip enable, active low.
- FB_WEN  out  1  FB write enable, active low; tied 1 (read-only).
- FB_A  out  12  FB address = y*64 + x.
- FB_Q  in  PIX_W  FB read data, valid the cycle after the clock edge that captured CEN=0.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  PIX_W  pixel colour.
- pix_x  out  XW  column of pix_data.
- pix_y  out  YW  row of pix_data.
- pix_sof  out  1  high with pixel (0,0).
- pix_eol  out  1  high with pix_x == 63.
- pix_eof  out  1  high with pixel (63,63).
- frame_done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset values: busy=0, own_bus=0, FB_CEN=1, FB_WEN=1, FB_A=0, pix_valid=0, pix_data/pix_x/pix_y=0, sof/eol/eof=0, frame_done=0. Address counter, in-flight flag and FIFO are cleared.
- States:
  - IDLE: frame_go=1 -> RUN.
  - RUN: issues reads; when address 4095 has been issued -> DRAIN.
  - DRAIN: FIFO empty and no read in flight -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- own_bus=busy=1 in RUN and DRAIN; 0 in IDLE and DONE.
- Handshake: a pixel transfers on any cycle with pix_valid & pix_ready. While pix_valid=1 and pix_ready=0, pix_data, pix_x, pix_y and the markers hold stable. pix_valid never drops without a transfer.
- Read issue:
  - credits = FIFO occupancy (0..2) + in-flight read (0..1); pop = pix_valid & pix_ready.
  - In RUN, FB_CEN=0 (combinational) iff credits<2, or credits==2 & pop.
  - FB_A = the address counter; the counter increments on every issued read and does not wrap past 4095.
  - FB_CEN=1 in every other state.
- Capture: the FB_Q word from the previous cycle's issued read is pushed into the FIFO together with its x/y (the address delayed by 1). Credit accounting guarantees the FIFO never overflows.
- Latency: frame_go sampled at edge E0 -> FB_CEN=0 with FB_A=0 during cycle E0..E1 -> pix_valid=1 with pixel 0 after E2.
- Throughput: with pix_ready held 1, one pixel per cycle; the last pixel is presented after E2+4095.
- Markers are combinational from the FIFO head coordinates: sof = (x==0 & y==0), eol = (x==63), eof = (x==63 & y==63).
- frame_done: asserted the cycle after the eof handshake plus the DRAIN->DONE transition, i.e. exactly one cycle after the handshake of pixel 4095.
- frame_go while busy or in DONE: ignored, no restart. frame_go held high continuously: one frame is accepted per IDLE visit.
- pix_ready toggling at the last pixel: eof holds until the transfer completes; frame_done follows that transfer.
- Reset mid-frame: within one cycle all outputs return to reset values; the in-flight read is discarded and the FIFO is flushed.

Test Plan:
- Preload FB[a]=a. Pulse frame_go, pix_ready=1 -> 4096 pixels in consecutive cycles; pixel n has data=n, x=n%64, y=n/64. sof only at n=0, eol at n%64==63, eof only at n=4095. First pix_valid 2 cycles after frame_go; frame_done pulses once, 1 cycle after pixel 4095.
- Same frame with pix_ready = 1,0,0,1,0 repeating -> identical pixel sequence with no drops or duplicates. Outputs are stable during stalls; FB_CEN is never low while credits==2 and no pop.
- Pulse frame_go again at pixel 100 -> ignored; still exactly 4096 pixels and one frame_done. After frame_done a new frame_go restarts at address 0.
- Assert reset for 1 cycle at pixel 2000 -> next cycle pix_valid=0, FB_CEN=1, own_bus=0, busy=0. A subsequent frame_go yields pixel 0 with data=0.
- Hold pix_ready=0 for 10 cycles while pixel 4095 is presented -> eof, data=4095 and busy stay stable. frame_done occurs exactly 1 cycle after pix_ready rises.
- Check FB_WEN=1 throughout all frames, and own_bus=0 whenever FB_CEN is driven by the drawing engine (IDLE) -> no FB write corruption during the engine's drawing phase.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Pixel stream from the frame-buffer scanout to the display/encoder stage.
// master = pixel source (fb_scanout), slave = downstream consumer.
interface fb_scanout_if #(
    parameter int PIX_W = 12,
    parameter int XW    = 6,
    parameter int YW    = 6
);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic [XW-1:0]    pix_x;
    logic [YW-1:0]    pix_y;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_eof;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/fb_scanout.sv
// Reads the 64x64 frame buffer in raster order after frame_go and streams the
// pixels with coordinates and frame/line markers through a 2-entry skid FIFO.
module fb_scanout #(
    parameter int PIX_W = 12,
    parameter int XW    = 6,
    parameter int YW    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_go,
    output logic                 busy,
    output logic                 own_bus,
    output logic                 FB_CEN,
    output logic                 FB_WEN,
    output logic [XW+YW-1:0]     FB_A,
    input  logic [PIX_W-1:0]     FB_Q,
    fb_scanout_if.master         pix,
    output logic                 frame_done
);
    localparam int AW = XW + YW;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [XW-1:0] LAST_X    = '1;
    localparam logic [YW-1:0] LAST_Y    = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    addr_d;
    logic             in_flight;
    logic [PIX_W-1:0] fifo_data [2];
    logic [AW-1:0]    fifo_addr [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       credits;
    logic             pop;
    logic             issue;
    logic [AW-1:0]    head_addr;
    logic [XW-1:0]    head_x;
    logic [YW-1:0]    head_y;

    // A read may only be issued if its data is guaranteed a FIFO slot on return.
    always_comb begin
        credits = count + {1'b0, in_flight};
        pop     = pix.pix_valid & pix.pix_ready;
        issue   = !reset && (state == RUN) &&
                  ((credits < 2'd2) || ((credits == 2'd2) && pop));
    end

    assign FB_CEN = !issue;
    assign FB_WEN = 1'b1;
    assign FB_A   = addr;

    assign head_addr     = fifo_addr[rd_ptr];
    assign head_x        = head_addr[XW-1:0];
    assign head_y        = head_addr[AW-1:XW];
    assign pix.pix_valid = (count != 2'd0);
    assign pix.pix_data  = fifo_data[rd_ptr];
    assign pix.pix_x     = head_x;
    assign pix.pix_y     = head_y;
    assign pix.pix_sof   = pix.pix_valid && (head_x == '0) && (head_y == '0);
    assign pix.pix_eol   = pix.pix_valid && (head_x == LAST_X);
    assign pix.pix_eof   = pix.pix_valid && (head_x == LAST_X) && (head_y == LAST_Y);

    // DRAIN exits on the cycle the last entry leaves, so frame_done lands
    // exactly one cycle after the final handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            own_bus    <= 1'b0;
            frame_done <= 1'b0;
            addr       <= '0;
            addr_d     <= '0;
            in_flight  <= 1'b0;
        end else begin
            in_flight  <= issue;
            frame_done <= 1'b0;
            if (issue) begin
                addr_d <= addr;
                if (addr != LAST_ADDR) begin
                    addr <= addr + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (frame_go) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        own_bus <= 1'b1;
                        addr    <= '0;
                    end
                end
                RUN: begin
                    if (issue && (addr == LAST_ADDR)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!in_flight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        own_bus    <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after issue and is pushed with its delayed address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_flight) begin
                fifo_data[wr_ptr] <= FB_Q;
                fifo_addr[wr_ptr] <= addr_d;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, in_flight} - {1'b0, pop};
        end
    end
endmodule
